seq_cmp_ctrl: RTL and testbench
===============================

# seq_cmp_ctrl

Sequencing controller that compares two wide unsigned operands by stepping a single 3-bit comparator slice across them, most-significant word first. It captures both operands on a start request, feeds one 3-bit word pair per cycle to the slice, and stops at the first unequal word. It returns a one-hot greater/less/equal result with a single-cycle done pulse. It sits between the wide-operand datapath and the 3-bit comparator primitive, so one small slice can serve any operand width.

## Interface
- WORDS, 4, number of 3-bit words per operand; operand width W = 3*WORDS; legal range 1..16
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  W  operand A, unsigned; sampled on the accepted start
- b  in  W  operand B, unsigned; sampled on the accepted start
- busy  out  1  high in SCAN and DONE
- done  out  1  one-cycle pulse when the result is valid
- gr  out  1  A > B
- le  out  1  A < B
- eq  out  1  A == B

## Operation
- FSM states are IDLE, SCAN and DONE.
- **IDLE:**
  - start=1 latches a and b into internal registers.
  - The word index is loaded with WORDS-1.
  - The next state is SCAN.
  - start=0 keeps the FSM in IDLE.
- **SCAN:**
  - The slice compares A[3*idx+2:3*idx] with B[3*idx+2:3*idx] combinationally.
  - If the slice reports unequal, or idx==0:
    - the slice outputs are registered into gr, le and eq;
    - the next state is DONE.
  - Otherwise idx decrements and the FSM stays in SCAN.
- **DONE:**
  - done=1 for exactly this one cycle.
  - The next state is IDLE.
- Results:
  - gr, le and eq hold their values until the next accepted start.
  - On an accepted start, gr, le and eq are cleared to 0.
  - When valid, exactly one of gr, le and eq is 1.
- start is ignored in SCAN and DONE; no request is queued.
- Changes on a and b after the accepted start have no effect on the result.
- The index counter is ceil(log2(WORDS)) bits wide, minimum 1. It never wraps below 0.

## Timing
- Reset values: state=IDLE, busy=0, done=0, gr=0, le=0, eq=0, idx=0.
- Start accepted at edge T means the FSM enters SCAN at T+1.
- The first differing word at index k gives done=1 in cycle T+2+(WORDS-1-k).
- Fastest result: the MSB word differs, so done=1 at T+2.
- Slowest result: all words equal, or only the LSB word differs, so done=1 at T+1+WORDS.
- WORDS=1: done=1 always at T+2.
- Back-to-back requests: start asserted while done=1 is ignored. The next request can be accepted in the cycle after done.
- Reset mid-SCAN or mid-DONE:
  - The FSM returns to IDLE on the next edge.
  - No done pulse is produced.
  - Results are cleared.

## Configuration
- **CMP_EARLY_EXIT_EN defined:** early termination as described above; latency depends on the data.
- **CMP_EARLY_EXIT_EN undefined:** SCAN always visits all WORDS words, so done=1 fixed at T+1+WORDS.
  - The first unequal word (most-significant) is recorded in a sticky "decided" flag plus the registered result.
  - Later words never overwrite a decided result.
  - If no word differs, the result is eq=1.
  - This mode gives constant-time compare.

## Structure
- Package seq_cmp_pkg contains:
  - state enum {IDLE, SCAN, DONE};
  - localparam WORD_W = 3;
  - the result encoding constants.
- Sub-module: comparator3bit, instantiated once as the per-word slice with ports (a, b, gr, le, eq). No other hierarchy.

## Test plan
Use WORDS=4 and octal operands.
- **MSB word differs:** a=12'o4000, b=12'o3777, start at T -> done at T+2 with gr=1, le=0, eq=0. Undefined macro: done at T+5 with gr=1.
- **All words equal:** a=b=12'o1234 -> done at T+5 with eq=1, and busy high from T+1 through T+5.
- **LSB word differs:** a=12'o1230, b=12'o1231 -> done at T+5 with le=1.
- **Start while busy:** assert start with a=12'o7777 during SCAN of a=12'o0100, b=12'o0200 -> ignored; le=1 at T+3. A new start accepted the cycle after done yields a fresh result.
- **Reset mid-operation:** rst=1 at T+2 of an all-equal compare -> no done; all outputs 0 at T+3; the FSM is back in IDLE.
- **Operand change after capture:** flip a and b at T+1 -> the result reflects the values captured at T.

Source files
------------

// File: rtl/seq_cmp_pkg.sv
// Shared types and constants for the word-serial wide-operand comparator.
package seq_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam int WORD_W = 3;

  // Result vector packing is {gr, le, eq}
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_GR   = 3'b100;
  localparam logic [2:0] RES_LE   = 3'b010;
  localparam logic [2:0] RES_EQ   = 3'b001;

endpackage

// File: rtl/seq_cmp_ctrl_comparator3bit.sv
// Single 3-bit unsigned magnitude comparator slice with one-hot outputs.
module comparator3bit (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic       gr,
  output logic       le,
  output logic       eq
);

  assign gr = (a > b);
  assign le = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/seq_cmp_ctrl.sv
// Word-serial wide comparator: steps one 3-bit slice from the MS word down.
// Build option CMP_EARLY_EXIT_EN: stop at the first unequal word; otherwise constant-time scan.
module seq_cmp_ctrl
  import seq_cmp_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WORD_W*WORDS-1:0] a,
  input  logic [WORD_W*WORDS-1:0] b,
  output logic                    busy,
  output logic                    done,
  output logic                    gr,
  output logic                    le,
  output logic                    eq
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t                    state_reg, state_next;
  logic [WORD_W*WORDS-1:0]   a_reg, a_next;
  logic [WORD_W*WORDS-1:0]   b_reg, b_next;
  logic [IDX_W-1:0]          idx_reg, idx_next;
  logic [2:0]                res_reg, res_next;
  logic                      decided_reg, decided_next;

  logic [WORD_W-1:0]         a_words [WORDS];
  logic [WORD_W-1:0]         b_words [WORDS];
  logic [WORD_W-1:0]         slice_a, slice_b;
  logic                      slice_gr, slice_le, slice_eq;
  logic [2:0]                slice_res;

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_words
      assign a_words[gi] = a_reg[gi*WORD_W +: WORD_W];
      assign b_words[gi] = b_reg[gi*WORD_W +: WORD_W];
    end
  endgenerate

  assign slice_a   = a_words[idx_reg];
  assign slice_b   = b_words[idx_reg];
  assign slice_res = {slice_gr, slice_le, slice_eq};

  comparator3bit u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .gr (slice_gr),
    .le (slice_le),
    .eq (slice_eq)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      idx_reg     <= '0;
      res_reg     <= RES_NONE;
      decided_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      idx_reg     <= idx_next;
      res_reg     <= res_next;
      decided_reg <= decided_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    idx_next     = idx_reg;
    res_next     = res_reg;
    decided_next = decided_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          a_next       = a;
          b_next       = b;
          idx_next     = IDX_W'(WORDS - 1);
          res_next     = RES_NONE;
          decided_next = 1'b0;
          state_next   = SCAN;
        end
      end
      SCAN: begin
`ifdef CMP_EARLY_EXIT_EN
        if (!slice_eq || idx_reg == '0) begin
          res_next     = slice_res;
          decided_next = 1'b1;
          state_next   = DONE;
        end else begin
          idx_next = idx_reg - 1'b1;
        end
`else
        // First unequal word wins; the last word supplies eq if nothing differed
        if (!decided_reg && (!slice_eq || idx_reg == '0)) begin
          res_next     = slice_res;
          decided_next = 1'b1;
        end
        if (idx_reg == '0) begin
          state_next = DONE;
        end else begin
          idx_next = idx_reg - 1'b1;
        end
`endif
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy         = (state_reg != IDLE);
  assign done         = (state_reg == DONE);
  assign {gr, le, eq} = res_reg;

endmodule

// File: tb/tb_seq_cmp_ctrl.sv
// Self-checking bench for seq_cmp_ctrl (WORDS=4) with a whole-number reference model.
module tb_seq_cmp_ctrl;

  localparam int WORDS = 4;
  localparam int W     = 3 * WORDS;
`ifdef CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, gr, le, eq;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  seq_cmp_ctrl #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .gr    (gr),
    .le    (le),
    .eq    (eq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference model: whole-number compare plus a countdown to the done cycle
  bit         m_busy = 1'b0;
  int         m_rem  = 0;
  logic [2:0] m_res  = 3'b000;
  logic [2:0] m_true = 3'b000;

  function automatic int latency(input logic [W-1:0] av, input logic [W-1:0] bv);
    if (EARLY) begin
      for (int k = WORDS - 1; k >= 0; k--) begin
        if (((av >> (3 * k)) & 7) != ((bv >> (3 * k)) & 7)) return 2 + (WORDS - 1 - k);
      end
    end
    return 1 + WORDS;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
      m_rem  = 0;
      m_res  = 3'b000;
    end else if (m_busy) begin
      if (m_rem == 0) begin
        m_busy = 1'b0;
      end else begin
        m_rem--;
        if (m_rem == 0) m_res = m_true;
      end
    end else if (start) begin
      m_busy = 1'b1;
      m_res  = 3'b000;
      m_rem  = latency(a, b) - 1;
      m_true = (a > b) ? 3'b100 : ((a < b) ? 3'b010 : 3'b001);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if (busy !== m_busy) begin
        fails++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, m_busy);
      end
      tests++;
      if (done !== (m_busy && m_rem == 0)) begin
        fails++;
        $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, (m_busy && m_rem == 0));
      end
      if (!m_busy || m_rem == 0) begin
        tests++;
        if ({gr, le, eq} !== m_res) begin
          fails++;
          $display("FAIL result cyc=%0d got=%b exp=%b", cyc, {gr, le, eq}, m_res);
        end
      end
    end
  end

  // mode 0: plain; 1: hold start with other operands while busy; 2: swap operands after capture
  task automatic run(input logic [W-1:0] av, input logic [W-1:0] bv, input int exp_lat,
                     input logic [2:0] exp_res, input int mode, input string name);
    int t0;
    int lat;
    bit got;
    lat   = -1;
    got   = 1'b0;
    a     = av;
    b     = bv;
    start = 1'b1;
    t0    = cyc;
    @(posedge clk); #1;
    if (mode == 1) begin
      a = 12'o7777;
      b = 12'o0000;
    end else begin
      start = 1'b0;
    end
    if (mode == 2) begin
      a = bv;
      b = av;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        lat = cyc - t0;
      end
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL %s timeout: no done within 40 cycles", name);
    end else begin
      if (lat != exp_lat) begin
        fails++;
        $display("FAIL %s latency got=%0d exp=%0d", name, lat, exp_lat);
      end
      tests++;
      if ({gr, le, eq} !== exp_res) begin
        fails++;
        $display("FAIL %s result got=%b exp=%b", name, {gr, le, eq}, exp_res);
      end
    end
    $display("[TB] %s a=%o b=%o latency=%0d gr/le/eq=%b", name, av, bv, lat, {gr, le, eq});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    tests++;
    if ({busy, done, gr, le, eq} !== 5'b00000) begin
      fails++;
      $display("FAIL reset_state got=%b exp=00000", {busy, done, gr, le, eq});
    end
    @(posedge clk); #1;

    run(12'o4000, 12'o3777, EARLY ? 2 : 5, 3'b100, 0, "msb_differs");
    run(12'o1234, 12'o1234, 5,             3'b001, 0, "all_equal");
    run(12'o1230, 12'o1231, 5,             3'b010, 0, "lsb_differs");
    run(12'o0100, 12'o0200, EARLY ? 3 : 5, 3'b010, 1, "start_while_busy");
    run(12'o0300, 12'o0200, EARLY ? 3 : 5, 3'b100, 0, "back_to_back");
    run(12'o5123, 12'o5127, 5,             3'b010, 2, "operand_change");
    run(12'o0000, 12'o7777, 2 + (EARLY ? 0 : 3), 3'b010, 0, "min_vs_max");

    // Reset during SCAN of an all-equal compare: asserted in cycle T+2
    a     = 12'o1234;
    b     = 12'o1234;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, done, gr, le, eq} !== 5'b00000) begin
      fails++;
      $display("FAIL reset_mid_scan got=%b exp=00000", {busy, done, gr, le, eq});
    end
    $display("[TB] reset_mid_scan outputs=%b", {busy, done, gr, le, eq});
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests++;
      if (done !== 1'b0) begin
        fails++;
        $display("FAIL reset_no_done cyc=%0d got=%b exp=0", cyc, done);
      end
    end
    @(posedge clk); #1;
    run(12'o7000, 12'o6777, EARLY ? 2 : 5, 3'b100, 0, "after_reset");

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
